// File: rtl/hazard_ctrl.sv
// Hazard controller: shadow EX/MEM destination state driving forward selects, load-use stall,
// branch flush and the data-memory stall FSM. Define HAZARD_PERF_CNT_EN to add performance counters.
module hazard_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [2:0] id_rs,
    input  logic [2:0] id_rt,
    input  logic       id_rs_used,
    input  logic       id_rt_used,
    input  logic       id_regwrt,
    input  logic       id_memrd,
    input  logic       id_memwrt,
    input  logic [2:0] id_write_reg,
    input  logic       ex_branch_taken,
    input  logic       dmem_stall,
    input  logic       dmem_done,
    output logic       EXFWD1_D,
    output logic       EXFWD2_D,
    output logic       MEMFWD1_D,
    output logic       MEMFWD2_D,
    output logic       hazard_stall,
    output logic       taking_branch,
    output logic       mem_stall,
    output logic       mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] load_use_count,
    output logic [15:0] flush_count
`endif
);

    typedef struct packed {
        logic       valid;
        logic       regwrt;
        logic       memrd;
        logic       memwrt;
        logic [2:0] dest;
    } shadow_t;

    typedef enum logic {IDLE, BUSY} mstate_t;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX    = CW'(TIMEOUT);
    localparam logic [CW-1:0] TMAX_M1 = CW'(TIMEOUT - 1);

    shadow_t       ex_q, mem_q, id_entry;
    mstate_t       state_q;
    logic [CW-1:0] tcnt_q;
    logic          timeout_q;

    logic       mem_access;
    logic [2:0] src [2];
    logic [1:0] used, ex_hit, mem_hit, ld_hit;
    logic       load_use, fwd_en;

    assign id_entry   = {id_valid, id_regwrt, id_memrd, id_memwrt, id_write_reg};
    assign mem_access = mem_q.valid & (mem_q.memrd | mem_q.memwrt);
    assign src[0]     = id_rs;
    assign src[1]     = id_rt;
    assign used       = {id_rt_used, id_rs_used};

    // Stall releases in the same cycle dmem_done is seen, so no extra bubble cycle.
    assign mem_stall     = (state_q == BUSY) ? ~dmem_done : (mem_access & dmem_stall);
    assign taking_branch = rst & ex_branch_taken & ~mem_stall;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_op
            assign ex_hit[gi]  = used[gi] & ex_q.valid & ex_q.regwrt & ~ex_q.memrd
                               & (ex_q.dest == src[gi]);
            assign mem_hit[gi] = used[gi] & mem_q.valid & mem_q.regwrt & (mem_q.dest == src[gi]);
            assign ld_hit[gi]  = used[gi] & (ex_q.dest == src[gi]);
        end
    endgenerate

    assign load_use     = id_valid & ex_q.valid & ex_q.memrd & ex_q.regwrt & (|ld_hit);
    assign hazard_stall = load_use & ~taking_branch & ~mem_stall;
    assign fwd_en       = id_valid & ~hazard_stall;

    assign EXFWD1_D  = fwd_en & ex_hit[0];
    assign EXFWD2_D  = fwd_en & ex_hit[1];
    assign MEMFWD1_D = fwd_en & mem_hit[0] & ~ex_hit[0];
    assign MEMFWD2_D = fwd_en & mem_hit[1] & ~ex_hit[1];
    assign mem_timeout = timeout_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else if (!mem_stall) begin
            mem_q <= ex_q;
            ex_q  <= (hazard_stall | taking_branch) ? '0 : id_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    tcnt_q <= '0;
                    if (mem_access & dmem_stall) state_q <= BUSY;
                end
                BUSY: begin
                    if (tcnt_q != TMAX)    tcnt_q    <= tcnt_q + 1'b1;
                    if (tcnt_q == TMAX_M1) timeout_q <= 1'b1;
                    if (dmem_done)         state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [2:0]  perf_inc;
    logic [15:0] perf_q [3];

    assign perf_inc = {taking_branch, hazard_stall, mem_stall};

    generate
        for (gi = 0; gi < 3; gi++) begin : g_perf
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)                                 perf_q[gi] <= '0;
                else if (perf_inc[gi] && ~&perf_q[gi])    perf_q[gi] <= perf_q[gi] + 16'd1;
            end
        end
    endgenerate

    assign stall_cycles   = perf_q[0];
    assign load_use_count = perf_q[1];
    assign flush_count    = perf_q[2];
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage forwarding/branch-predict core. It drives the forward-select, stall and flush inputs that the ID/EX, EX/MEM and MEM/WB pipeline registers sample. It keeps a shadow copy of destination-register state for the EX and MEM stages and derives the following from it and the decode-stage operands:

- EX/MEM forward selects
- load-use stalls
- branch flushes
- the data-memory stall handshake

## Interface
Parameters:
- TIMEOUT, 64: max cycles in BUSY before `mem_timeout` is raised.

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  decode stage holds a real instruction
- id_rs, id_rt  in  3 each  decode source register numbers
- id_rs_used, id_rt_used  in  1 each  source is actually read
- id_regwrt  in  1  decode instruction writes a register
- id_memrd  in  1  decode instruction is a load
- id_memwrt  in  1  decode instruction is a store
- id_write_reg  in  3  decode destination register
- ex_branch_taken  in  1  EX resolved a mispredicted/taken branch or jump
- dmem_stall  in  1  data memory cannot complete this cycle
- dmem_done  in  1  data memory completes the outstanding access
- EXFWD1_D, EXFWD2_D  out  1 each  forward the EX result to operand 1/2
- MEMFWD1_D, MEMFWD2_D  out  1 each  forward the MEM result to operand 1/2
- hazard_stall  out  1  load-use stall: hold PC and IF/ID, insert a bubble into ID/EX
- taking_branch  out  1  flush IF/ID and ID/EX
- mem_stall  out  1  freeze the whole pipeline
- mem_timeout  out  1  sticky error flag

## Operation
**Shadow pipeline**
- Two entries, EX and MEM. Each holds {valid, regwrt, memrd, memwrt, dest[2:0]}.
- Each cycle, with no stall: MEM←EX, and EX←ID fields.
- When mem_stall=1: both entries hold.
- When hazard_stall=1 or taking_branch=1: EX receives a bubble (all zero) while MEM←EX.

**Forwarding** (combinational)
- EX match: id_rsN_used & ex.valid & ex.regwrt & ~ex.memrd & ex.dest==id_rsN.
- MEM match: same conditions against mem.valid & mem.regwrt & mem.dest; loads are allowed here.
- EX has priority. If both match, only the EXFWD bit is set.
- All forward outputs are 0 when id_valid=0 or hazard_stall=1.

**Load-use**
- hazard_stall = id_valid & ex.valid & ex.memrd & ex.regwrt & (rs or rt matches ex.dest, with the used bit set).
- Lasts exactly one cycle. On the next cycle the load sits in MEM and MEMFWD is asserted instead.

**Branch flush**
- taking_branch = ex_branch_taken & ~mem_stall.
- A flush overrides hazard_stall: hazard_stall is forced to 0 when taking_branch=1.

**Memory FSM** (states IDLE, BUSY)
- IDLE: if mem.valid & (mem.memrd|mem.memwrt) & dmem_stall, go to BUSY. mem_stall=1 in the same cycle.
- BUSY: mem_stall = ~dmem_done. On dmem_done, go to IDLE, with mem_stall=0 that cycle.
- Timeout counter: cleared in IDLE, increments in BUSY, saturates at TIMEOUT. Reaching TIMEOUT sets mem_timeout, which stays set until reset.

**Priority**
- mem_stall > taking_branch > hazard_stall.
- While mem_stall=1, taking_branch and hazard_stall are both 0.

## Timing
- Reset (rst=0, async): shadow entries cleared, FSM in IDLE, counter 0. All outputs are 0.
- Forward/stall/flush outputs are combinational from inputs and registered state, valid before the next clk edge.
- mem_stall asserts in the same cycle dmem_stall is seen and releases in the dmem_done cycle. Zero added latency.
- Simultaneous dmem_done and ex_branch_taken in BUSY: mem_stall=0 and taking_branch=1 in that cycle.
- Reset asserted mid-BUSY: FSM returns to IDLE immediately; mem_timeout clears.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - Adds outputs stall_cycles[15:0], load_use_count[15:0] and flush_count[15:0].
  - All three are saturating counters, reset to 0.
  - stall_cycles increments every cycle mem_stall=1; load_use_count once per hazard_stall cycle; flush_count once per taking_branch cycle.
- Undefined: the counters and their ports are absent. All other behaviour is identical.

## Test plan
- Load r3 in EX, ID reads r3 as rs:
  - hazard_stall=1 for 1 cycle.
  - Next cycle: MEMFWD1_D=1, EXFWD1_D=0.
- ALU writes r2 in EX and an older ALU writes r2 in MEM; ID reads r2 on rt: EXFWD2_D=1, MEMFWD2_D=0.
- MEM entry is a store and dmem_stall=1 for 3 cycles, then dmem_done:
  - mem_stall=1 for exactly 3 cycles.
  - Shadow state unchanged across the stall.
- ex_branch_taken=1 together with a load-use condition: taking_branch=1, hazard_stall=0, EX shadow entry becomes a bubble.
- dmem_stall held with no dmem_done for TIMEOUT=64 cycles:
  - mem_timeout=1 after the 64th BUSY cycle.
  - rst low clears it asynchronously and returns the FSM to IDLE.
- With HAZARD_PERF_CNT_EN: 3-cycle memory stall plus 2 flushes gives stall_cycles=3, flush_count=2.
